transposed_fir_accum_stage: RTL and testbench

//  Downstream consumer of the per-tap coefficient multipliers (16s x 14ns -> 30-bit signed products).

---
 rtl/transposed_fir_accum_stage.sv | 132 +++++++++++++
 tb/tb_transposed_fir_accum_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/transposed_fir_accum_stage.sv
// Transposed-form FIR delay/add chain fed by a bank of per-tap products.
// Tap-0 sum is rounded, saturated and held in a valid/ready output register.
module transposed_fir_accum_stage #(
  parameter int NTAPS  = 16,
  parameter int PROD_W = 30,
  parameter int ACC_W  = 34,
  parameter int SHIFT  = 14,
  parameter int OUT_W  = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      flush,
  input  logic [NTAPS*PROD_W-1:0]   in_prod,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sat_flag
);

  localparam int RND_W = ACC_W + 1;
  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1) << (SHIFT - 1);
  localparam logic signed [RND_W-1:0] OUT_MAX  = (RND_W'(1) << (OUT_W - 1)) - RND_W'(1);
  localparam logic signed [RND_W-1:0] OUT_MIN  = ~OUT_MAX;

  logic signed [ACC_W-1:0] prod_ext [NTAPS];
  logic signed [ACC_W-1:0] hist     [1:NTAPS-1];
  logic signed [ACC_W-1:0] s_q      [1:NTAPS-1];
  logic signed [ACC_W-1:0] s_d      [1:NTAPS-1];

  logic                    accept;
  logic signed [ACC_W-1:0] acc;
  logic signed [RND_W-1:0] acc_rnd;
  logic signed [RND_W-1:0] rnd_q14;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [OUT_W-1:0]        sat_val;

  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    sat_q, sat_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_ext
      assign prod_ext[gi] = {{(ACC_W-PROD_W){in_prod[gi*PROD_W+PROD_W-1]}},
                             in_prod[gi*PROD_W +: PROD_W]};
    end

    // A flush coinciding with an accept makes this sample see an empty history.
    for (gi = 1; gi < NTAPS; gi++) begin : g_hist
      assign hist[gi] = flush ? '0 : s_q[gi];
    end

    for (gi = 1; gi < NTAPS - 1; gi++) begin : g_chain
      assign s_d[gi] = prod_ext[gi] + hist[gi+1];
    end
  endgenerate

  assign s_d[NTAPS-1] = prod_ext[NTAPS-1];

  assign acc     = prod_ext[0] + hist[1];
  assign acc_rnd = {acc[ACC_W-1], acc} + RND_HALF;
  assign rnd_q14 = acc_rnd >>> SHIFT;
  assign sat_hi  = rnd_q14 > OUT_MAX;
  assign sat_lo  = rnd_q14 < OUT_MIN;

  always_comb begin
    sat_val = rnd_q14[OUT_W-1:0];
    if (sat_hi) begin
      sat_val = OUT_MAX[OUT_W-1:0];
    end else if (sat_lo) begin
      sat_val = OUT_MIN[OUT_W-1:0];
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sat_val;
      sat_d       = (sat_q && !flush) || sat_hi || sat_lo;
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
      if (flush) begin
        sat_d = 1'b0;
      end
    end
  end

  // The chain only steps on an accepted sample; bubbles leave it untouched.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int k = 1; k < NTAPS; k++) begin
        s_q[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 1; k < NTAPS; k++) begin
        s_q[k] <= s_d[k];
      end
    end else if (flush) begin
      for (int k = 1; k < NTAPS; k++) begin
        s_q[k] <= '0;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_transposed_fir_accum_stage.sv
// Bench for transposed_fir_accum_stage: a direct-form convolution model over the
// accepted-sample history predicts every output, valid bit and saturation flag.
module tb_transposed_fir_accum_stage;

  localparam int NTAPS  = 16;
  localparam int PROD_W = 30;
  localparam int ACC_W  = 34;
  localparam int SHIFT  = 14;
  localparam int OUT_W  = 16;

  typedef logic [NTAPS*PROD_W-1:0] vec_t;

  logic             ap_clk = 1'b0;
  logic             ap_rst;
  logic             flush;
  vec_t             in_prod;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             sat_flag;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t             hist_q[$];
  logic [OUT_W-1:0] m_out;
  bit               m_ovalid;
  bit               m_sat;

  transposed_fir_accum_stage #(
    .NTAPS(NTAPS), .PROD_W(PROD_W), .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .flush(flush), .in_prod(in_prod),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic longint tap(vec_t v, int j);
    logic signed [PROD_W-1:0] t;
    t = v[j*PROD_W +: PROD_W];
    return longint'(t);
  endfunction

  function automatic vec_t fill(longint val);
    vec_t v;
    for (int k = 0; k < NTAPS; k++) v[k*PROD_W +: PROD_W] = PROD_W'(val);
    return v;
  endfunction

  function automatic vec_t impulse_vec();
    vec_t v;
    for (int k = 0; k < NTAPS; k++) v[k*PROD_W +: PROD_W] = PROD_W'(k * 16384);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < NTAPS; k++)
      v[k*PROD_W +: PROD_W] = PROD_W'(int'($urandom) >>> $urandom_range(2, 18));
    return v;
  endfunction

  // Output(n) = sum over taps j of tap j of the sample accepted j samples ago.
  task automatic model_edge(vec_t v, bit val, bit ordy, bit fl, bit rst);
    longint acc, r, mx, mn;
    if (rst) begin
      hist_q.delete();
      m_out = '0; m_ovalid = 0; m_sat = 0;
      return;
    end
    if (val && (!m_ovalid || ordy)) begin
      if (fl) begin hist_q.delete(); m_sat = 0; end
      hist_q.push_front(v);
      acc = 0;
      foreach (hist_q[j]) if (j < NTAPS) acc += tap(hist_q[j], j);
      while (hist_q.size() > NTAPS - 1) void'(hist_q.pop_back());
      r  = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      mx = (longint'(1) <<< (OUT_W - 1)) - 1;
      mn = -mx - 1;
      if (r > mx) begin r = mx; m_sat = 1; end
      else if (r < mn) begin r = mn; m_sat = 1; end
      m_out = OUT_W'(r);
      m_ovalid = 1;
    end else begin
      if (fl) begin hist_q.delete(); m_sat = 0; end
      if (ordy) m_ovalid = 0;
    end
  endtask

  task automatic cycle(vec_t v, bit val, bit ordy, bit fl, bit rst);
    in_prod = v; in_valid = val; out_ready = ordy; flush = fl; ap_rst = rst;
    @(posedge ap_clk);
    model_edge(v, val, ordy, fl, rst);
    #1;
  endtask

  task automatic test_reset();
    cycle(rand_vec(), 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(rand_vec(), 1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b expected 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset out_data got %0d expected 0", $signed(out_data)); end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset sat_flag got %b expected 0", sat_flag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b expected 1", in_ready); end
    ap_rst = 1'b0;
  endtask

  task automatic test_impulse(string tag);
    cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < NTAPS + 3; n++) begin
      cycle(n == 0 ? impulse_vec() : vec_t'(0), 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ($signed(out_data) !== ((n < NTAPS) ? n : 0) || out_data !== m_out) begin
        n_fail++; $display("FAIL %s[%0d] out_data got %0d expected %0d", tag, n, $signed(out_data), (n < NTAPS) ? n : 0);
      end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s[%0d] out_valid got %b expected 1", tag, n, out_valid); end
    end
  endtask

  task automatic test_rounding();
    int pv [5] = '{8192, 8191, -8192, -8193, 24576};
    int ev [5] = '{1, 0, 0, -1, 2};
    vec_t v;
    for (int i = 0; i < 5; i++) begin
      v = '0;
      v[0 +: PROD_W] = PROD_W'(pv[i]);
      cycle(rand_vec(), 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(v, 1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ($signed(out_data) !== ev[i] || out_data !== m_out) begin
        n_fail++; $display("FAIL round[%0d] p0=%0d out_data got %0d expected %0d", i, pv[i], $signed(out_data), ev[i]);
      end
    end
  endtask

  task automatic test_saturation();
    cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < NTAPS; n++) begin
      cycle(fill((longint'(1) <<< 29) - 1), 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++; if (out_data !== m_out) begin n_fail++; $display("FAIL sat_pos[%0d] out_data got %0d expected %0d", n, $signed(out_data), $signed(m_out)); end
      n_checks++; if (sat_flag !== m_sat) begin n_fail++; $display("FAIL sat_pos[%0d] sat_flag got %b expected %b", n, sat_flag, m_sat); end
    end
    n_checks++; if ($signed(out_data) !== 32767) begin n_fail++; $display("FAIL sat_pos_final out_data got %0d expected 32767", $signed(out_data)); end
    for (int n = 0; n < NTAPS; n++) begin
      cycle(fill(-(longint'(1) <<< 29)), 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++; if (out_data !== m_out) begin n_fail++; $display("FAIL sat_neg[%0d] out_data got %0d expected %0d", n, $signed(out_data), $signed(m_out)); end
      n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_neg[%0d] sat_flag got %b expected 1", n, sat_flag); end
    end
    n_checks++; if ($signed(out_data) !== -32768) begin n_fail++; $display("FAIL sat_neg_final out_data got %0d expected -32768", $signed(out_data)); end
    cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_flush sat_flag got %b expected 0", sat_flag); end
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] held;
    cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) cycle(rand_vec(), 1'b1, 1'b1, 1'b0, 1'b0);
    held = m_out;
    for (int n = 0; n < 4; n++) begin
      cycle(rand_vec(), 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++; if (out_data !== held) begin n_fail++; $display("FAIL bp_hold[%0d] out_data got %0d expected %0d", n, $signed(out_data), $signed(held)); end
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d] valid/ready got %b/%b expected 1/0", n, out_valid, in_ready); end
    end
    for (int n = 0; n < NTAPS + 2; n++) begin
      cycle(n < 3 ? rand_vec() : vec_t'(0), 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++; if (out_data !== m_out || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume[%0d] out_data got %0d expected %0d", n, $signed(out_data), $signed(m_out)); end
    end
  endtask

  task automatic test_flush_accept();
    vec_t v;
    int p0, er;
    cycle(fill((longint'(1) <<< 29) - 1), 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(impulse_vec(), 1'b1, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b1, 1'b0, 1'b0);
    v  = rand_vec();
    p0 = $urandom_range(0, 200000) - 100000;
    v[0 +: PROD_W] = PROD_W'(p0);
    er = (p0 + 8192) >>> 14;
    cycle(v, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++; if ($signed(out_data) !== er) begin n_fail++; $display("FAIL flush_acc out_data got %0d expected %0d", $signed(out_data), er); end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL flush_acc sat_flag got %b expected 0", sat_flag); end
    for (int n = 0; n < 4; n++) begin
      cycle('0, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++; if (out_data !== m_out) begin n_fail++; $display("FAIL flush_tail[%0d] out_data got %0d expected %0d", n, $signed(out_data), $signed(m_out)); end
    end
  endtask

  task automatic test_reset_midstream();
    cycle(fill((longint'(1) <<< 29) - 1), 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(rand_vec(), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(rand_vec(), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(rand_vec(), 1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid got %b expected 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL midrst out_data got %0d expected 0", $signed(out_data)); end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL midrst sat_flag got %b expected 0", sat_flag); end
    ap_rst = 1'b0;
    test_impulse("post_rst_impulse");
  endtask

  task automatic test_random();
    bit val, ordy, fl;
    for (int n = 0; n < 400; n++) begin
      val  = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      cycle(rand_vec(), val, ordy, fl, 1'b0);
      n_checks++;
      if (out_valid !== m_ovalid || (m_ovalid && out_data !== m_out)) begin
        n_fail++; $display("FAIL rand[%0d] valid/data got %b/%0d expected %b/%0d", n, out_valid, $signed(out_data), m_ovalid, $signed(m_out));
      end
      n_checks++; if (sat_flag !== m_sat) begin n_fail++; $display("FAIL rand[%0d] sat_flag got %b expected %b", n, sat_flag, m_sat); end
      n_checks++; if (in_ready !== (!m_ovalid || ordy)) begin n_fail++; $display("FAIL rand[%0d] in_ready got %b expected %b", n, in_ready, !m_ovalid || ordy); end
    end
  endtask

  initial begin
    ap_rst = 1'b1; flush = 1'b0; in_prod = '0; in_valid = 1'b0; out_ready = 1'b0;
    m_out = '0; m_ovalid = 0; m_sat = 0;
    test_reset();
    test_impulse("impulse");
    test_rounding();
    test_saturation();
    test_backpressure();
    test_flush_accept();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
